// File: rtl/func_pkg.sv
// Shared types and constants for the cube-plus-root arithmetic unit.
// Pure declarations: no latency, no flow control.
package func_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL1 = 2'd1,
      MUL2 = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int MUL_CYCLES = 8;
   localparam int SQRT_ITERS = 4;
   localparam int OP_W       = 8;
   localparam int RES_W      = 24;

endpackage

// File: rtl/func_mul.sv
// Shift-add multiplier, 16b x 8b -> 24b; start performs the first of 8 iterations.
// Latency 8 edges including the start edge; done marks the final iteration cycle; no backpressure.
module func_mul
   import func_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start,
   input  logic [15:0]      mcand,
   input  logic [OP_W-1:0]  mplier,
   output logic [RES_W-1:0] prod,
   output logic             done
);

   logic [RES_W-1:0] mc_q;
   logic [OP_W-1:0]  mp_q;
   logic [3:0]       cnt_q;
   logic             run_q;

   // High during the cycle whose closing edge adds the last partial product.
   assign done = run_q && (cnt_q == 4'(MUL_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         prod  <= '0;
         mc_q  <= '0;
         mp_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         prod  <= mplier[0] ? RES_W'(mcand) : '0;
         mc_q  <= RES_W'(mcand) << 1;
         mp_q  <= mplier >> 1;
         cnt_q <= 4'd1;
         run_q <= 1'b1;
      end else if (run_q) begin
         prod  <= prod + (mp_q[0] ? mc_q : '0);
         mc_q  <= mc_q << 1;
         mp_q  <= mp_q >> 1;
         cnt_q <= cnt_q + 4'd1;
         if (done)
            run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/func_unit.sv
// Computes y = a^3 + floor(sqrt(b)) with one shared multiplier used twice.
// Latency 17 cycles accept-to-result; start_i ignored while busy_o is high.
module func_unit
   import func_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [OP_W-1:0]  a_i,
   input  logic [OP_W-1:0]  b_i,
   output logic             busy_o,
   output logic [RES_W-1:0] y_o
);

   state_t           state_q;
   logic [OP_W-1:0]  a_q;
   logic [OP_W-1:0]  b_q;
   logic [3:0]       root_q;
   logic [7:0]       rem_q;
   logic [2:0]       sq_cnt_q;
   logic             mul_go_q;

   logic [15:0]      mul_mcand;
   logic [RES_W-1:0] mul_prod;
   logic             mul_done;

   logic [7:0]       rem_sh;
   logic [7:0]       trial;
   logic             sq_fit;

   // First pass squares a; second pass multiplies that square by a again.
   assign mul_mcand = (state_q == MUL2) ? mul_prod[15:0] : {8'd0, a_q};

   // One restoring step: bring down the next bit pair, try subtracting 4*root+1.
   assign rem_sh = (rem_q << 2) | {6'd0, b_q[7:6]};
   assign trial  = {2'd0, root_q, 2'b01};
   assign sq_fit = (rem_sh >= trial);

   func_mul u_mul (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start  (mul_go_q),
      .mcand  (mul_mcand),
      .mplier (a_q),
      .prod   (mul_prod),
      .done   (mul_done)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         root_q   <= '0;
         rem_q    <= '0;
         sq_cnt_q <= '0;
         mul_go_q <= 1'b0;
         busy_o   <= 1'b0;
         y_o      <= '0;
      end else begin
         mul_go_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  a_q      <= a_i;
                  b_q      <= b_i;
                  root_q   <= '0;
                  rem_q    <= '0;
                  sq_cnt_q <= '0;
                  mul_go_q <= 1'b1;
                  busy_o   <= 1'b1;
                  state_q  <= MUL1;
               end
            end
            MUL1: begin
               if (sq_cnt_q != 3'(SQRT_ITERS)) begin
                  rem_q    <= sq_fit ? (rem_sh - trial) : rem_sh;
                  root_q   <= {root_q[2:0], sq_fit};
                  b_q      <= b_q << 2;
                  sq_cnt_q <= sq_cnt_q + 3'd1;
               end
               if (mul_done) begin
                  mul_go_q <= 1'b1;
                  state_q  <= MUL2;
               end
            end
            MUL2: begin
               if (mul_done)
                  state_q <= DONE;
            end
            DONE: begin
               y_o     <= mul_prod + RES_W'(root_q);
               busy_o  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_func_unit.sv
// Directed bench for func_unit: hand-computed vectors, handshake and reset cases.
module tb_func_unit;

   logic        clk_i;
   logic        rst_i;
   logic        start_i;
   logic [7:0]  a_i;
   logic [7:0]  b_i;
   logic        busy_o;
   logic [23:0] y_o;

   int checks;
   int errors;

   func_unit dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .busy_o  (busy_o),
      .y_o     (y_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Accept one operation, wait for busy_o to fall, check length, stability and result.
   task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [23:0] exp,
                      input string tag, input bit disturb);
      int          n;
      logic [23:0] y_prev;
      bit          stable;
      a_i     = a;
      b_i     = b;
      start_i = 1'b1;
      y_prev  = y_o;
      tick();
      start_i = 1'b0;
      check({tag, " busy_rise"}, 32'(busy_o), 32'd1);
      n      = 0;
      stable = 1'b1;
      while (busy_o && n < 40) begin
         if (y_o !== y_prev)
            stable = 1'b0;
         if (disturb) begin
            a_i     = 8'($urandom);
            b_i     = 8'($urandom);
            start_i = (n == 3);
         end
         tick();
         n++;
      end
      start_i = 1'b0;
      check({tag, " busy_cycles"}, 32'(n), 32'd17);
      check({tag, " y_stable"}, 32'(stable), 32'd1);
      check({tag, " y"}, 32'(y_o), 32'(exp));
   endtask

   initial begin
      int n;
      checks  = 0;
      errors  = 0;
      rst_i   = 1'b0;
      start_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      tick();
      tick();
      check("reset busy", 32'(busy_o), 32'd0);
      check("reset y", 32'(y_o), 32'd0);
      rst_i = 1'b1;
      tick();

      run(8'd0,   8'd0,   24'd0,        "min",      1'b0);
      run(8'd15,  8'd15,  24'd3378,     "sweep15",  1'b0);
      run(8'd30,  8'd30,  24'd27005,    "sweep30",  1'b0);
      run(8'd240, 8'd240, 24'd13824015, "sweep240", 1'b0);
      run(8'd2,   8'd224, 24'd22,       "sq224",    1'b0);
      run(8'd2,   8'd225, 24'd23,       "sq225",    1'b0);
      run(8'd1,   8'd3,   24'd2,        "sq3",      1'b0);
      run(8'd1,   8'd4,   24'd3,        "sq4",      1'b0);
      run(8'd255, 8'd255, 24'd16581390, "max",      1'b0);

      // Operands and start toggled while busy must not affect anything.
      run(8'd100, 8'd50, 24'd1000007, "disturb", 1'b1);
      tick();
      check("disturb no_requeue", 32'(busy_o), 32'd0);
      check("disturb y_hold", 32'(y_o), 32'd1000007);

      // start_i held high: second accept on the edge after busy_o falls.
      a_i     = 8'd3;
      b_i     = 8'd9;
      start_i = 1'b1;
      tick();
      check("held busy_rise", 32'(busy_o), 32'd1);
      n = 0;
      while (busy_o && n < 40) begin
         if (n == 5) begin
            a_i = 8'd4;
            b_i = 8'd16;
         end
         tick();
         n++;
      end
      check("held busy_cycles", 32'(n), 32'd17);
      check("held y1", 32'(y_o), 32'd30);
      tick();
      check("held reaccept", 32'(busy_o), 32'd1);
      start_i = 1'b0;
      n = 0;
      while (busy_o && n < 40) begin
         tick();
         n++;
      end
      check("held busy_cycles2", 32'(n), 32'd17);
      check("held y2", 32'(y_o), 32'd68);

      // Reset in cycle 9 of a computation aborts it immediately.
      a_i     = 8'd10;
      b_i     = 8'd100;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 8; i++)
         tick();
      check("midrst busy_before", 32'(busy_o), 32'd1);
      rst_i = 1'b0;
      #1;
      check("midrst busy", 32'(busy_o), 32'd0);
      check("midrst y", 32'(y_o), 32'd0);
      tick();
      rst_i = 1'b1;
      tick();
      check("midrst idle", 32'(busy_o), 32'd0);
      run(8'd5, 8'd200, 24'd139, "post_rst", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
